// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand capture, stall/flush, bubble counter.
// Optional EX/MEM and MEM/WB operand forwarding under ID_EX_FORWARDING_EN.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 8
) (
  input  logic              inp_clk,
  input  logic              inp_rst,
  input  logic              inp_stall,
  input  logic              inp_flush,
  input  logic              inp_valid,
  input  logic [REG_AW-1:0] inp_rs1Addr,
  input  logic [REG_AW-1:0] inp_rs2Addr,
  input  logic [REG_AW-1:0] inp_rdAddr,
  input  logic [DATA_W-1:0] inp_regData1,
  input  logic [DATA_W-1:0] inp_regData2,
  input  logic [DATA_W-1:0] inp_imm,
  input  logic              inp_aluSrc,
  input  logic [2:0]        inp_aluControl,
  input  logic              inp_regWrite,
  input  logic              inp_memRegWrite,
  input  logic [REG_AW-1:0] inp_memRdAddr,
  input  logic [DATA_W-1:0] inp_memData,
  input  logic              inp_wbRegWrite,
  input  logic [REG_AW-1:0] inp_wbRdAddr,
  input  logic [DATA_W-1:0] inp_wbData,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [2:0]        out_aluControl,
  output logic [REG_AW-1:0] out_rdAddr,
  output logic              out_regWrite,
  output logic [CNT_W-1:0]  out_bubbleCount
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [2:0]        alu_ctrl;
    logic              alu_src;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] imm;
  } id_ex_t;

  id_ex_t           q;
  id_ex_t           d_load;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    d_load = '0;
    if (inp_valid) begin
      d_load.valid     = 1'b1;
      d_load.reg_write = inp_regWrite;
      d_load.alu_ctrl  = inp_aluControl;
      d_load.alu_src   = inp_aluSrc;
      d_load.rs1       = inp_rs1Addr;
      d_load.rs2       = inp_rs2Addr;
      d_load.rd        = inp_rdAddr;
      d_load.d1        = inp_regData1;
      d_load.d2        = inp_regData2;
      d_load.imm       = inp_imm;
    end
  end

  always_ff @(posedge inp_clk or posedge inp_rst) begin
    if (inp_rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (inp_flush) begin
      q <= '0;
      if (cnt != {CNT_W{1'b1}})
        cnt <= cnt + 1'b1;
    end else if (!inp_stall) begin
      q <= d_load;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  // EX/MEM wins over MEM/WB; r0 never forwards.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] rs,
    input logic [DATA_W-1:0] v
  );
    if (rs == '0)
      return v;
    else if (inp_memRegWrite && inp_memRdAddr == rs)
      return inp_memData;
    else if (inp_wbRegWrite && inp_wbRdAddr == rs)
      return inp_wbData;
    else
      return v;
  endfunction

  assign out_data1 = fwd(q.rs1, q.d1);
  assign out_data2 = q.alu_src ? q.imm
                               : fwd(q.rs2, q.d2);
`else
  logic unused_fwd;
  assign unused_fwd = ^{inp_memRegWrite, inp_memRdAddr,
                        inp_memData, inp_wbRegWrite,
                        inp_wbRdAddr, inp_wbData,
                        q.rs1, q.rs2};
  assign out_data1 = q.d1;
  assign out_data2 = q.alu_src ? q.imm : q.d2;
`endif

  assign out_valid       = q.valid;
  assign out_aluControl  = q.alu_ctrl;
  assign out_rdAddr      = q.rd;
  assign out_regWrite    = q.reg_write & q.valid;
  assign out_bubbleCount = cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage with a behavioural model.
// Expectations follow ID_EX_FORWARDING_EN when it is defined.
module tb_id_ex_stage;

  logic        inp_clk = 1'b0;
  logic        inp_rst = 1'b1;
  logic        inp_stall = 1'b0;
  logic        inp_flush = 1'b0;
  logic        inp_valid = 1'b0;
  logic [2:0]  inp_rs1Addr = '0;
  logic [2:0]  inp_rs2Addr = '0;
  logic [2:0]  inp_rdAddr = '0;
  logic [15:0] inp_regData1 = '0;
  logic [15:0] inp_regData2 = '0;
  logic [15:0] inp_imm = '0;
  logic        inp_aluSrc = 1'b0;
  logic [2:0]  inp_aluControl = '0;
  logic        inp_regWrite = 1'b0;
  logic        inp_memRegWrite = 1'b0;
  logic [2:0]  inp_memRdAddr = '0;
  logic [15:0] inp_memData = '0;
  logic        inp_wbRegWrite = 1'b0;
  logic [2:0]  inp_wbRdAddr = '0;
  logic [15:0] inp_wbData = '0;
  logic        out_valid;
  logic [15:0] out_data1;
  logic [15:0] out_data2;
  logic [2:0]  out_aluControl;
  logic [2:0]  out_rdAddr;
  logic        out_regWrite;
  logic [7:0]  out_bubbleCount;

  int total = 0;
  int bad = 0;

  // model: the instruction currently held, plus bubble count
  logic        m_valid, m_rw, m_src;
  logic [2:0]  m_alu, m_rs1, m_rs2, m_rd;
  logic [15:0] m_d1, m_d2, m_imm;
  int          m_cnt;

  id_ex_stage dut (
    .inp_clk(inp_clk), .inp_rst(inp_rst),
    .inp_stall(inp_stall), .inp_flush(inp_flush),
    .inp_valid(inp_valid),
    .inp_rs1Addr(inp_rs1Addr), .inp_rs2Addr(inp_rs2Addr),
    .inp_rdAddr(inp_rdAddr),
    .inp_regData1(inp_regData1), .inp_regData2(inp_regData2),
    .inp_imm(inp_imm), .inp_aluSrc(inp_aluSrc),
    .inp_aluControl(inp_aluControl),
    .inp_regWrite(inp_regWrite),
    .inp_memRegWrite(inp_memRegWrite),
    .inp_memRdAddr(inp_memRdAddr), .inp_memData(inp_memData),
    .inp_wbRegWrite(inp_wbRegWrite),
    .inp_wbRdAddr(inp_wbRdAddr), .inp_wbData(inp_wbData),
    .out_valid(out_valid), .out_data1(out_data1),
    .out_data2(out_data2), .out_aluControl(out_aluControl),
    .out_rdAddr(out_rdAddr), .out_regWrite(out_regWrite),
    .out_bubbleCount(out_bubbleCount)
  );

  always #5 inp_clk = ~inp_clk;

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_src = 0; m_alu = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_d1 = 0; m_d2 = 0; m_imm = 0;
  endtask

  task automatic model_edge();
    if (inp_rst) begin
      model_clear();
      m_cnt = 0;
    end else if (inp_flush) begin
      model_clear();
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end else if (!inp_stall) begin
      if (!inp_valid) model_clear();
      else begin
        m_valid = 1; m_rw = inp_regWrite;
        m_src = inp_aluSrc; m_alu = inp_aluControl;
        m_rs1 = inp_rs1Addr; m_rs2 = inp_rs2Addr;
        m_rd = inp_rdAddr; m_d1 = inp_regData1;
        m_d2 = inp_regData2; m_imm = inp_imm;
      end
    end
  endtask

  function automatic logic [15:0] src_val(
    input logic [2:0] rs, input logic [15:0] stored);
`ifdef ID_EX_FORWARDING_EN
    if (rs != 0 && inp_memRegWrite && inp_memRdAddr == rs)
      return inp_memData;
    if (rs != 0 && inp_wbRegWrite && inp_wbRdAddr == rs)
      return inp_wbData;
`endif
    return stored;
  endfunction

  function automatic logic [15:0] exp_d1();
    return src_val(m_rs1, m_d1);
  endfunction

  function automatic logic [15:0] exp_d2();
    return m_src ? m_imm : src_val(m_rs2, m_d2);
  endfunction

  task automatic step();
    @(posedge inp_clk);
    model_edge();
    #1;
  endtask

  task automatic drive_instr(
    input logic [2:0] rs1, input logic [2:0] rs2,
    input logic [2:0] rd, input logic [15:0] r1,
    input logic [15:0] r2, input logic [15:0] imm,
    input logic src, input logic [2:0] alu);
    inp_valid = 1; inp_regWrite = 1;
    inp_rs1Addr = rs1; inp_rs2Addr = rs2; inp_rdAddr = rd;
    inp_regData1 = r1; inp_regData2 = r2; inp_imm = imm;
    inp_aluSrc = src; inp_aluControl = alu;
  endtask

  task automatic test_reset();
    inp_rst = 1; step(); inp_rst = 0;
    total++;
    if ({out_valid, out_regWrite, out_aluControl,
         out_data1, out_data2, out_bubbleCount} !== '0) begin
      bad++;
      $display("FAIL reset_init: outputs=%h required 0",
        {out_valid, out_regWrite, out_aluControl,
         out_data1, out_data2, out_bubbleCount});
    end
    drive_instr(3'd1, 3'd2, 3'd5, 16'h1234, 16'h5678,
                16'h0abc, 1'b0, 3'd6);
    inp_flush = 1; step(); inp_flush = 0;
    step();
    #2 inp_rst = 1; #1;
    total++;
    if ({out_valid, out_regWrite, out_aluControl,
         out_data1, out_data2, out_bubbleCount} !== '0) begin
      bad++;
      $display("FAIL reset_async: outputs=%h required 0",
        {out_valid, out_regWrite, out_aluControl,
         out_data1, out_data2, out_bubbleCount});
    end
    model_clear(); m_cnt = 0;
    inp_rst = 0;
  endtask

  task automatic test_load_imm();
    drive_instr(3'd1, 3'd2, 3'd4, 16'd4, 16'd3, 16'd9,
                1'b1, 3'd2);
    step();
    total++;
    if ({out_data1, out_data2, out_aluControl, out_valid}
        !== {16'd4, 16'd9, 3'd2, 1'b1}) begin
      bad++;
      $display("FAIL load_imm: d1=%0d d2=%0d alu=%0d v=%0b required 4 9 2 1",
        out_data1, out_data2, out_aluControl, out_valid);
    end
    inp_aluSrc = 0;
    step();
    total++;
    if (out_data2 !== 16'd3 || out_rdAddr !== 3'd4
        || out_regWrite !== 1'b1) begin
      bad++;
      $display("FAIL load_reg: d2=%0d rd=%0d rw=%0b required 3 4 1",
        out_data2, out_rdAddr, out_regWrite);
    end
  endtask

  task automatic test_stall_flush();
    inp_stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive_instr(3'($urandom), 3'($urandom), 3'($urandom),
        16'($urandom), 16'($urandom), 16'($urandom),
        1'($urandom), 3'($urandom));
      step();
      total++;
      if ({out_data1, out_data2, out_aluControl, out_valid,
           out_rdAddr} !== {16'd4, 16'd3, 3'd2, 1'b1, 3'd4}) begin
        bad++;
        $display("FAIL stall_hold: d1=%0d d2=%0d alu=%0d v=%0b rd=%0d required 4 3 2 1 4",
          out_data1, out_data2, out_aluControl, out_valid, out_rdAddr);
      end
    end
    inp_flush = 1;
    step();
    total++;
    if ({out_valid, out_regWrite, out_aluControl,
         out_bubbleCount} !== {1'b0, 1'b0, 3'd0, 8'd1}) begin
      bad++;
      $display("FAIL flush_stall: v=%0b rw=%0b alu=%0d cnt=%0d required 0 0 0 1",
        out_valid, out_regWrite, out_aluControl, out_bubbleCount);
    end
    inp_stall = 0;
    drive_instr(3'd0, 3'd0, 3'd0, 16'd0, 16'd0, 16'd0,
                1'b0, 3'd0);
    inp_valid = 0;
    inp_flush = 0;
    step();
    total++;
    if (out_bubbleCount !== 8'd1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL invalid_load: cnt=%0d v=%0b required 1 0",
        out_bubbleCount, out_valid);
    end
    inp_flush = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 253) begin
        total++;
        if (out_bubbleCount !== 8'd255) begin
          bad++;
          $display("FAIL count_reach: cnt=%0d required 255",
            out_bubbleCount);
        end
      end
    end
    inp_flush = 0;
    total++;
    if (out_bubbleCount !== 8'd255) begin
      bad++;
      $display("FAIL count_sat: cnt=%0d required 255",
        out_bubbleCount);
    end
  endtask

  task automatic test_forwarding();
    logic [15:0] e_mem, e_wb;
`ifdef ID_EX_FORWARDING_EN
    e_mem = 16'h0011; e_wb = 16'h0022;
`else
    e_mem = 16'd5; e_wb = 16'd5;
`endif
    drive_instr(3'd2, 3'd6, 3'd1, 16'd5, 16'd7, 16'd0,
                1'b0, 3'd1);
    step();
    inp_stall = 1;
    inp_memRegWrite = 1; inp_memRdAddr = 2; inp_memData = 16'h0011;
    inp_wbRegWrite = 1; inp_wbRdAddr = 2; inp_wbData = 16'h0022;
    #1;
    total++;
    if (out_data1 !== e_mem) begin
      bad++;
      $display("FAIL fwd_mem: d1=%h required %h", out_data1, e_mem);
    end
    inp_memRegWrite = 0;
    #1;
    total++;
    if (out_data1 !== e_wb) begin
      bad++;
      $display("FAIL fwd_wb: d1=%h required %h", out_data1, e_wb);
    end
    inp_stall = 0;
    drive_instr(3'd0, 3'd3, 3'd1, 16'd0, 16'd8, 16'h1234,
                1'b1, 3'd3);
    inp_memRegWrite = 1; inp_memRdAddr = 0; inp_memData = 16'hffff;
    inp_wbRegWrite = 0;
    step();
    total++;
    if (out_data1 !== 16'd0) begin
      bad++;
      $display("FAIL fwd_r0: d1=%h required 0000", out_data1);
    end
    inp_memRdAddr = 3;
    #1;
    total++;
    if (out_data2 !== 16'h1234) begin
      bad++;
      $display("FAIL fwd_imm: d2=%h required 1234", out_data2);
    end
    inp_memRegWrite = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      inp_flush = ($urandom_range(0, 9) == 0);
      inp_stall = ($urandom_range(0, 4) == 0);
      inp_valid = ($urandom_range(0, 4) != 0);
      inp_rs1Addr = 3'($urandom); inp_rs2Addr = 3'($urandom);
      inp_rdAddr = 3'($urandom);
      inp_regData1 = 16'($urandom); inp_regData2 = 16'($urandom);
      inp_imm = 16'($urandom); inp_aluSrc = 1'($urandom);
      inp_aluControl = 3'($urandom); inp_regWrite = 1'($urandom);
      inp_memRegWrite = 1'($urandom); inp_memRdAddr = 3'($urandom);
      inp_memData = 16'($urandom);
      inp_wbRegWrite = 1'($urandom); inp_wbRdAddr = 3'($urandom);
      inp_wbData = 16'($urandom);
      step();
      total++;
      if ({out_valid, out_regWrite, out_aluControl, out_rdAddr}
          !== {m_valid, m_rw & m_valid, m_alu, m_rd}) begin
        bad++;
        $display("FAIL rand_ctrl[%0d]: v=%0b rw=%0b alu=%0d rd=%0d required %0b %0b %0d %0d",
          i, out_valid, out_regWrite, out_aluControl, out_rdAddr,
          m_valid, m_rw & m_valid, m_alu, m_rd);
      end
      total++;
      if (out_data1 !== exp_d1() || out_data2 !== exp_d2()) begin
        bad++;
        $display("FAIL rand_data[%0d]: d1=%h d2=%h required %h %h",
          i, out_data1, out_data2, exp_d1(), exp_d2());
      end
      total++;
      if (out_bubbleCount !== 8'(m_cnt)) begin
        bad++;
        $display("FAIL rand_cnt[%0d]: cnt=%0d required %0d",
          i, out_bubbleCount, m_cnt);
      end
    end
    inp_flush = 0; inp_stall = 0;
  endtask

  initial begin
    model_clear(); m_cnt = 0;
    test_reset();
    test_load_imm();
    test_stall_flush();
    test_forwarding();
    inp_rst = 1; step(); inp_rst = 0;
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
